// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - two-port Avalon-MM SDRAM arbiter with in-order read tag FIFO; define SDRAM_ARB_FIXED_PRIO_EN for fixed port-0 priority
module sdram_arbiter #(
    parameter int ADDR_W   = 25,
    parameter int DATA_W   = 16,
    parameter int MAX_PEND = 8
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [ADDR_W-1:0] s0_address,
    input  logic              s0_read,
    input  logic              s0_write,
    input  logic [DATA_W-1:0] s0_writedata,
    input  logic [1:0]        s0_byteenable,
    output logic              s0_waitrequest,
    output logic [DATA_W-1:0] s0_readdata,
    output logic              s0_readdatavalid,
    input  logic [ADDR_W-1:0] s1_address,
    input  logic              s1_read,
    input  logic              s1_write,
    input  logic [DATA_W-1:0] s1_writedata,
    input  logic [1:0]        s1_byteenable,
    output logic              s1_waitrequest,
    output logic [DATA_W-1:0] s1_readdata,
    output logic              s1_readdatavalid,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [DATA_W-1:0] m_writedata,
    output logic [1:0]        m_byteenable,
    input  logic              m_waitrequest,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_readdatavalid
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GNT0 = 2'd1;
    localparam logic [1:0] ST_GNT1 = 2'd2;
    localparam int PTR_W = $clog2(MAX_PEND);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(MAX_PEND);

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [MAX_PEND-1:0] r_tag;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W:0]      r_count;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
    logic                r_last;
`endif

    logic       w_req0, w_req1, w_granted, w_sel, w_own_req, w_oth_req;
    logic       w_sel_read, w_sel_write, w_full, w_empty;
    logic       w_accept, w_push, w_pop, w_head;
    logic [1:0] w_oth_state, w_prio_state;

    assign w_req0       = s0_read | s0_write;
    assign w_req1       = s1_read | s1_write;
    assign w_granted    = (r_state == ST_GNT0) || (r_state == ST_GNT1);
    assign w_sel        = (r_state == ST_GNT1);
    assign w_own_req    = w_sel ? w_req1 : w_req0;
    assign w_oth_req    = w_sel ? w_req0 : w_req1;
    assign w_oth_state  = w_sel ? ST_GNT0 : ST_GNT1;
    assign w_prio_state = w_req0 ? ST_GNT0 : (w_req1 ? ST_GNT1 : ST_IDLE);
    assign w_sel_read   = w_granted & (w_sel ? s1_read : s0_read);
    assign w_sel_write  = w_granted & (w_sel ? s1_write : s0_write);

    // A full tag FIFO blocks the granted read; the registered count means a pop only helps next cycle
    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // Master port is a copy of the granted port, all zero when idle
    assign m_read       = w_sel_read & ~w_full;
    assign m_write      = w_sel_write;
    assign m_address    = w_granted ? (w_sel ? s1_address : s0_address) : '0;
    assign m_writedata  = w_granted ? (w_sel ? s1_writedata : s0_writedata) : '0;
    assign m_byteenable = w_granted ? (w_sel ? s1_byteenable : s0_byteenable) : '0;

    assign w_accept = (m_read | m_write) & ~m_waitrequest;
    assign w_push   = w_accept & m_read;
    assign w_pop    = m_readdatavalid & ~w_empty;
    assign w_head   = r_tag[r_rd_ptr];

    assign s0_waitrequest   = ~((r_state == ST_GNT0) & ~m_waitrequest & ~(w_sel_read & w_full));
    assign s1_waitrequest   = ~((r_state == ST_GNT1) & ~m_waitrequest & ~(w_sel_read & w_full));
    assign s0_readdata      = m_readdata;
    assign s1_readdata      = m_readdata;
    assign s0_readdatavalid = w_pop & ~w_head;
    assign s1_readdatavalid = w_pop & w_head;

    // Next grant: pick on request from idle, hand over on acceptance, release when the owner goes quiet
    always_comb begin
        w_next_state = r_state;
        if (!w_granted) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
            w_next_state = w_prio_state;
`else
            if (w_req0 && w_req1) begin
                w_next_state = r_last ? ST_GNT0 : ST_GNT1;
            end else begin
                w_next_state = w_prio_state;
            end
`endif
        end else if (w_accept) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
            w_next_state = w_prio_state;
`else
            if (w_oth_req) begin
                w_next_state = w_oth_state;
            end else if (!w_own_req) begin
                w_next_state = ST_IDLE;
            end
`endif
        end else if (!w_own_req) begin
            w_next_state = w_oth_req ? w_oth_state : ST_IDLE;
        end
    end

    // Grant state register
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

`ifndef SDRAM_ARB_FIXED_PRIO_EN
    // Remember the last port served; reset to 1 so port 0 wins the first tie
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_last <= 1'b1;
        end else if (w_accept) begin
            r_last <= w_sel;
        end
    end
`endif

    // In-order tag FIFO routing each returned read word to its issuing port
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_tag    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_tag[r_wr_ptr] <= w_sel;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end
endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-port Avalon-MM arbiter in front of the SDRAM controller in the `soc_system` fabric. It shares the single 16-bit SDRAM controller slave between two masters: the Nios II data path (port 0) and a custom DMA/accelerator (port 1). It grants one port at a time, round-robin by default. Pipelined reads are supported, and each `readdatavalid` is routed back to the port that issued the read through an in-order tag FIFO.

## Interface

Parameters:
- `ADDR_W`, 25, word address width (16-bit words, 64 MB).
- `DATA_W`, 16, data width.
- `MAX_PEND`, 8, maximum outstanding reads (power of 2, ≥2).

Ports:
- `clk_clk`  in  1  single clock, all logic rising-edge.
- `reset_reset_n`  in  1  asynchronous, active-low reset.
- `s0_address`/`s1_address`  in  ADDR_W  slave address.
- `s0_read`/`s1_read`  in  1  read request.
- `s0_write`/`s1_write`  in  1  write request (read and write are never both high on one port).
- `s0_writedata`/`s1_writedata`  in  DATA_W  write data.
- `s0_byteenable`/`s1_byteenable`  in  2  byte enables.
- `s0_waitrequest`/`s1_waitrequest`  out  1  stall.
- `s0_readdata`/`s1_readdata`  out  DATA_W  read data.
- `s0_readdatavalid`/`s1_readdatavalid`  out  1  read data strobe.
- `m_address`  out  ADDR_W  address to the SDRAM controller.
- `m_read`, `m_write`  out  1  commands to the SDRAM controller.
- `m_writedata`  out  DATA_W  write data to the SDRAM controller.
- `m_byteenable`  out  2  byte enables to the SDRAM controller.
- `m_waitrequest`  in  1  stall from the SDRAM controller.
- `m_readdata`  in  DATA_W  read data from the SDRAM controller.
- `m_readdatavalid`  in  1  read data strobe from the SDRAM controller.

## Operation

- FSM states:
  - IDLE: no port is connected.
  - GNT0: port 0 is muxed to the master port.
  - GNT1: port 1 is muxed to the master port.
  - The state register and `last` (the port most recently granted) are the only arbitration state.
- IDLE transitions:
  - One port requests (read|write): go to that port's GNT state.
  - Both ports request: go to the port ≠ `last`.
- GNTn: master port signals are combinational copies of port n.
- A transfer is accepted when `m_read|m_write` is high and `m_waitrequest` is low. On acceptance, set `last`=n, then:
  - Other port requesting: go to the other GNT state.
  - Else, port n still requesting: stay in GNTn.
  - Else: go to IDLE.
- `sN_waitrequest` = 0 only when in GNTN and `m_waitrequest` = 0 and the transfer is not read-blocked; otherwise 1.
- A port that is not granted always sees `sN_waitrequest`=1.
- Tag FIFO (MAX_PEND deep, 1-bit entries):
  - Push the port ID on each accepted read.
  - Pop on `m_readdatavalid`.
  - Push and pop in the same cycle: occupancy is unchanged.
- Read blocking: when the FIFO is full (occupancy = MAX_PEND), a granted read is blocked. `m_read` is forced to 0 and `sN_waitrequest`=1.
- A pop in the same cycle does not unblock that cycle. The block is lifted next cycle.
- Writes are never blocked by the FIFO.
- Read return: `sT_readdatavalid` = `m_readdatavalid` where T is the FIFO head tag; the other port's `readdatavalid` stays 0.
- Both `sN_readdata` = `m_readdata` (unconditional fan-out).
- `m_readdatavalid` with an empty FIFO is an error. It is dropped, and no port strobes.
- Reset mid-operation:
  - FSM goes to IDLE, `last`=1 (so port 0 wins the first tie), FIFO empties.
  - In-flight read data arriving after reset is dropped.

## Timing

- Reset values:
  - `m_read`=0, `m_write`=0, `m_address`=0, `m_writedata`=0, `m_byteenable`=0.
  - `s0_waitrequest`=`s1_waitrequest`=1.
  - `s0_readdatavalid`=`s1_readdatavalid`=0.
- Arbitration latency: a request seen in IDLE at edge k appears on the master port in cycle k+1. This costs one bubble.
- Back-to-back transfers from GNTn move directly to the next GNT state with no bubble.
- Under continuous requests from both ports, accepted transfers alternate 0,1,0,1.
- Read return path is combinational (zero added latency). Data is returned strictly in issue order.
- In IDLE all master outputs are 0.

## Configuration

- Macro `SDRAM_ARB_FIXED_PRIO_EN`.
- Defined:
  - Port 0 always wins when both ports request.
  - On acceptance in GNT1, go to GNT0 if port 0 is requesting. In GNT0, stay while port 0 requests.
  - `last` is unused.
- Undefined: round-robin as described in Operation.

## Test plan

- Reset with both ports requesting → all outputs at reset values. First grant after reset release is port 0; `m_read` rises one cycle after IDLE sees the request.
- Both ports issue 4 writes each continuously, `m_waitrequest`=0 → master port sees the sequence 0,1,0,1,0,1,0,1. With `SDRAM_ARB_FIXED_PRIO_EN` → 0,0,0,0,1,1,1,1.
- Port 0 reads 0x10, then port 1 reads 0x20, then port 0 reads 0x30. Controller returns 0xAAAA, 0xBBBB, 0xCCCC with 3-cycle latency → `s0_readdatavalid` strobes for 0xAAAA and 0xCCCC, `s1_readdatavalid` strobes only for 0xBBBB.
- Port 1 issues 9 reads with no `m_readdatavalid` (MAX_PEND=8) → 8 accepted; the 9th holds `s1_waitrequest`=1 with `m_read`=0. The 9th is accepted the cycle after the first `m_readdatavalid`.
- `m_waitrequest` held high 5 cycles during a port 0 write while port 1 requests → grant stays GNT0 and `m_address`/`m_writedata` stay stable. Port 1 is granted the cycle after acceptance.
- `reset_reset_n` pulsed low with 3 reads outstanding, then 3 `m_readdatavalid` pulses arrive → no `sN_readdatavalid` strobes; FIFO empty.
